// File: rtl/axi_lite_reg_bridge_mc.sv
// AXI4-Lite slave that decodes single-beat reads and writes onto NUM_CH register channels.
// Write and read paths are independent FSMs, each with its own ack timeout.
module axi_lite_reg_bridge_mc #(
    parameter int AXI_ADDR_WIDTH = 32,
    parameter int AXI_DATA_WIDTH = 32,
    parameter int NUM_CH         = 4,
    parameter int CH_ADDR_BITS   = 12,
    parameter int ACK_TIMEOUT    = 255
) (
    input  logic                             s_axi_aclk,
    input  logic                             s_axi_aresetn,
    input  logic [AXI_ADDR_WIDTH-1:0]        s_axi_awaddr,
    input  logic                             s_axi_awvalid,
    output logic                             s_axi_awready,
    input  logic [AXI_DATA_WIDTH-1:0]        s_axi_wdata,
    input  logic [AXI_DATA_WIDTH/8-1:0]      s_axi_wstrb,
    input  logic                             s_axi_wvalid,
    output logic                             s_axi_wready,
    output logic [1:0]                       s_axi_bresp,
    output logic                             s_axi_bvalid,
    input  logic                             s_axi_bready,
    input  logic [AXI_ADDR_WIDTH-1:0]        s_axi_araddr,
    input  logic                             s_axi_arvalid,
    output logic                             s_axi_arready,
    output logic [AXI_DATA_WIDTH-1:0]        s_axi_rdata,
    output logic [1:0]                       s_axi_rresp,
    output logic                             s_axi_rvalid,
    input  logic                             s_axi_rready,
    output logic [NUM_CH-1:0]                wr_en,
    output logic [CH_ADDR_BITS-1:0]          waddr,
    output logic [AXI_DATA_WIDTH-1:0]        wdata,
    output logic [AXI_DATA_WIDTH/8-1:0]      wstrb,
    input  logic [NUM_CH-1:0]                wr_ack,
    output logic [NUM_CH-1:0]                rd_en,
    output logic [CH_ADDR_BITS-1:0]          raddr,
    input  logic [NUM_CH*AXI_DATA_WIDTH-1:0] rdata,
    input  logic [NUM_CH-1:0]                rd_ack
);
    localparam int CH_SEL_BITS = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam int SB          = AXI_DATA_WIDTH / 8;
    localparam int HI_SHIFT    = CH_ADDR_BITS + CH_SEL_BITS;
    localparam logic [15:0] TMO_LAST = 16'(ACK_TIMEOUT - 1);
    localparam logic [1:0] RESP_OKAY = 2'b00, RESP_SLVERR = 2'b10, RESP_DECERR = 2'b11;

    typedef enum logic [1:0] {W_IDLE, W_ISSUE, W_WAIT, W_RESP} w_state_t;
    typedef enum logic [1:0] {R_IDLE, R_ISSUE, R_WAIT, R_RESP} r_state_t;

    function automatic logic dec_err(input logic [AXI_ADDR_WIDTH-1:0] a);
        logic [AXI_ADDR_WIDTH-1:0] hi;
        logic [CH_SEL_BITS-1:0]    ch;
        hi = a >> HI_SHIFT;
        ch = a[CH_ADDR_BITS +: CH_SEL_BITS];
        return (hi != '0) || (int'(ch) >= NUM_CH);
    endfunction

    // A transfer happens on a rising edge where valid && ready; valid never waits for ready.
    w_state_t                  w_state, w_next;
    logic                      aw_full, w_full, aw_hs, w_hs, b_hs, aw_have, w_have;
    logic [AXI_ADDR_WIDTH-1:0] aw_addr_q, aw_addr_cur;
    logic [AXI_DATA_WIDTH-1:0] w_data_q, w_data_cur;
    logic [SB-1:0]             w_strb_q, w_strb_cur;
    logic [CH_SEL_BITS-1:0]    w_ch;
    logic                      w_derr, w_ack_hit, w_tmo;
    logic [NUM_CH-1:0]         w_sel;
    logic [15:0]               w_cnt;

    assign aw_hs       = s_axi_awvalid && s_axi_awready;
    assign w_hs        = s_axi_wvalid && s_axi_wready;
    assign b_hs        = s_axi_bvalid && s_axi_bready;
    assign aw_have     = aw_full || aw_hs;
    assign w_have      = w_full || w_hs;
    assign aw_addr_cur = aw_full ? aw_addr_q : s_axi_awaddr;
    assign w_data_cur  = w_full ? w_data_q : s_axi_wdata;
    assign w_strb_cur  = w_full ? w_strb_q : s_axi_wstrb;
    assign w_sel       = NUM_CH'(1) << w_ch;
    assign w_ack_hit   = |(wr_ack & w_sel);
    assign w_tmo       = (w_cnt == TMO_LAST);

    always_ff @(posedge s_axi_aclk or negedge s_axi_aresetn) begin
        if (!s_axi_aresetn) w_state <= W_IDLE;
        else                w_state <= w_next;
    end

    always_comb begin
        w_next = w_state;
        wr_en  = '0;
        case (w_state)
            W_IDLE:  if (aw_have && w_have) w_next = W_ISSUE;
            W_ISSUE: begin
                if (w_derr) begin
                    w_next = W_RESP;
                end else begin
                    wr_en  = w_sel;
                    w_next = W_WAIT;
                end
            end
            W_WAIT:  if (w_ack_hit || w_tmo) w_next = W_RESP;
            W_RESP:  if (b_hs) w_next = W_IDLE;
            default: w_next = W_IDLE;
        endcase
    end

    always_ff @(posedge s_axi_aclk or negedge s_axi_aresetn) begin
        if (!s_axi_aresetn) begin
            aw_full       <= 1'b0;
            w_full        <= 1'b0;
            aw_addr_q     <= '0;
            w_data_q      <= '0;
            w_strb_q      <= '0;
            s_axi_awready <= 1'b0;
            s_axi_wready  <= 1'b0;
            waddr         <= '0;
            wdata         <= '0;
            wstrb         <= '0;
            w_ch          <= '0;
            w_derr        <= 1'b0;
            w_cnt         <= '0;
            s_axi_bvalid  <= 1'b0;
            s_axi_bresp   <= '0;
        end else begin
            if (aw_hs) aw_addr_q <= s_axi_awaddr;
            if (w_hs) begin
                w_data_q <= s_axi_wdata;
                w_strb_q <= s_axi_wstrb;
            end
            // Holding registers stay full until the B handshake retires the write.
            aw_full       <= aw_have && !b_hs;
            w_full        <= w_have && !b_hs;
            s_axi_awready <= (w_next == W_IDLE) && !(aw_have && !b_hs);
            s_axi_wready  <= (w_next == W_IDLE) && !(w_have && !b_hs);
            if (w_state == W_IDLE && w_next == W_ISSUE) begin
                waddr  <= aw_addr_cur[CH_ADDR_BITS-1:0];
                wdata  <= w_data_cur;
                wstrb  <= w_strb_cur;
                w_ch   <= aw_addr_cur[CH_ADDR_BITS +: CH_SEL_BITS];
                w_derr <= dec_err(aw_addr_cur);
            end
            w_cnt <= (w_state == W_WAIT && w_next == W_WAIT) ? w_cnt + 16'd1 : '0;
            if (w_state != W_RESP && w_next == W_RESP) begin
                s_axi_bvalid <= 1'b1;
                s_axi_bresp  <= w_derr ? RESP_DECERR : (w_ack_hit ? RESP_OKAY : RESP_SLVERR);
            end else if (b_hs) begin
                s_axi_bvalid <= 1'b0;
            end
        end
    end

    r_state_t                  r_state, r_next;
    logic                      ar_hs, r_hs, r_derr, r_ack_hit, r_tmo;
    logic [CH_SEL_BITS-1:0]    r_ch;
    logic [NUM_CH-1:0]         r_sel;
    logic [15:0]               r_cnt;
    logic [AXI_DATA_WIDTH-1:0] rd_slice;

    assign ar_hs     = s_axi_arvalid && s_axi_arready;
    assign r_hs      = s_axi_rvalid && s_axi_rready;
    assign r_sel     = NUM_CH'(1) << r_ch;
    assign r_ack_hit = |(rd_ack & r_sel);
    assign r_tmo     = (r_cnt == TMO_LAST);

    always_comb begin
        rd_slice = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            if (c == int'(r_ch)) rd_slice = rdata[c*AXI_DATA_WIDTH +: AXI_DATA_WIDTH];
        end
    end

    always_ff @(posedge s_axi_aclk or negedge s_axi_aresetn) begin
        if (!s_axi_aresetn) r_state <= R_IDLE;
        else                r_state <= r_next;
    end

    always_comb begin
        r_next = r_state;
        rd_en  = '0;
        case (r_state)
            R_IDLE:  if (ar_hs) r_next = R_ISSUE;
            R_ISSUE: begin
                if (r_derr) begin
                    r_next = R_RESP;
                end else begin
                    rd_en  = r_sel;
                    r_next = R_WAIT;
                end
            end
            R_WAIT:  if (r_ack_hit || r_tmo) r_next = R_RESP;
            R_RESP:  if (r_hs) r_next = R_IDLE;
            default: r_next = R_IDLE;
        endcase
    end

    always_ff @(posedge s_axi_aclk or negedge s_axi_aresetn) begin
        if (!s_axi_aresetn) begin
            s_axi_arready <= 1'b0;
            raddr         <= '0;
            r_ch          <= '0;
            r_derr        <= 1'b0;
            r_cnt         <= '0;
            s_axi_rvalid  <= 1'b0;
            s_axi_rresp   <= '0;
            s_axi_rdata   <= '0;
        end else begin
            s_axi_arready <= (r_next == R_IDLE);
            if (ar_hs) begin
                raddr  <= s_axi_araddr[CH_ADDR_BITS-1:0];
                r_ch   <= s_axi_araddr[CH_ADDR_BITS +: CH_SEL_BITS];
                r_derr <= dec_err(s_axi_araddr);
            end
            r_cnt <= (r_state == R_WAIT && r_next == R_WAIT) ? r_cnt + 16'd1 : '0;
            if (r_state != R_RESP && r_next == R_RESP) begin
                s_axi_rvalid <= 1'b1;
                if (r_derr) begin
                    s_axi_rresp <= RESP_DECERR;
                    s_axi_rdata <= '0;
                end else if (r_ack_hit) begin
                    s_axi_rresp <= RESP_OKAY;
                    s_axi_rdata <= rd_slice;
                end else begin
                    s_axi_rresp <= RESP_SLVERR;
                    s_axi_rdata <= '0;
                end
            end else if (r_hs) begin
                s_axi_rvalid <= 1'b0;
            end
        end
    end

endmodule
